// File: rtl/alu_op_issuer.sv
// MIPS32 decode stage feeding the ALU: turns an instruction plus its register operands into an
// ALU op code, operands and writeback/trap qualifiers behind a valid/ready output with a skid entry.
module alu_op_issuer #(
    parameter int         DW       = 32,
    parameter logic [3:0] ILL_CODE = 4'h0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   instr,
    input  logic [DW-1:0] rs_val,
    input  logic [DW-1:0] rt_val,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    alu_con,
    output logic [DW-1:0] op_a,
    output logic [DW-1:0] op_b,
    output logic [4:0]    dest,
    output logic          chk_ov,
    output logic          is_branch,
    output logic          illegal
);

    typedef struct packed {
        logic [3:0]    alu_con;
        logic [DW-1:0] op_a;
        logic [DW-1:0] op_b;
        logic [4:0]    dest;
        logic          chk_ov;
        logic          is_branch;
        logic          illegal;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] ins, input logic [DW-1:0] rs,
                                    input logic [DW-1:0] rt);
        dec_t          d;
        logic [5:0]    opc;
        logic [5:0]    fn;
        logic [DW-1:0] sext;
        logic [DW-1:0] zext;
        logic [DW-1:0] shz;
        opc  = ins[31:26];
        fn   = ins[5:0];
        sext = {{(DW-16){ins[15]}}, ins[15:0]};
        zext = {{(DW-16){1'b0}}, ins[15:0]};
        shz  = {{(DW-5){1'b0}}, ins[10:6]};
        d      = '0;
        d.op_a = rs;
        case (opc)
            6'h00: begin
                d.op_b = rt;
                d.dest = ins[15:11];
                case (fn)
                    6'h20: begin d.alu_con = 4'h0; d.chk_ov = 1'b1; end
                    6'h22: begin d.alu_con = 4'h1; d.chk_ov = 1'b1; end
                    6'h24: d.alu_con = 4'h2;
                    6'h25: d.alu_con = 4'h3;
                    6'h26: d.alu_con = 4'h4;
                    6'h27: d.alu_con = 4'h5;
                    6'h21: d.alu_con = 4'hE;
                    6'h23: d.alu_con = 4'hF;
                    // Shifts take the shifted value from rt and the amount from shamt
                    6'h00: begin d.alu_con = 4'h6; d.op_a = rt; d.op_b = shz; end
                    6'h02: begin d.alu_con = 4'h7; d.op_a = rt; d.op_b = shz; end
                    default: d.illegal = 1'b1;
                endcase
            end
            6'h08: begin d.alu_con = 4'h0; d.op_b = sext; d.dest = ins[20:16]; d.chk_ov = 1'b1; end
            6'h09: begin d.alu_con = 4'hE; d.op_b = sext; d.dest = ins[20:16]; end
            6'h0C: begin d.alu_con = 4'h2; d.op_b = zext; d.dest = ins[20:16]; end
            6'h0D: begin d.alu_con = 4'h3; d.op_b = zext; d.dest = ins[20:16]; end
            6'h0E: begin d.alu_con = 4'h4; d.op_b = zext; d.dest = ins[20:16]; end
            6'h23: begin d.alu_con = 4'hE; d.op_b = sext; d.dest = ins[20:16]; end
            6'h2B: begin d.alu_con = 4'hE; d.op_b = sext; d.dest = 5'd0; end
            6'h04: begin d.alu_con = 4'h8; d.op_b = rt; d.is_branch = 1'b1; end
            6'h05: begin d.alu_con = 4'h9; d.op_b = rt; d.is_branch = 1'b1; end
            6'h06: begin d.alu_con = 4'hC; d.op_b = '0; d.is_branch = 1'b1; end
            6'h07: begin d.alu_con = 4'hB; d.op_b = '0; d.is_branch = 1'b1; end
            default: d.illegal = 1'b1;
        endcase
        if (d.illegal) begin
            d         = '0;
            d.alu_con = ILL_CODE;
            d.illegal = 1'b1;
        end else begin
            d.illegal = 1'b0;
        end
        return d;
    endfunction

    dec_t dec_s;
    dec_t out_r;
    dec_t skid_r;
    logic out_valid_r;
    logic skid_valid_r;
    logic accept_s;
    logic load_s;
    logic unused_s;

    // Register source fields are not needed; operand values arrive already read
    assign unused_s = ^instr[25:21];

    // Decode the presented instruction and derive handshake qualifiers
    always_comb begin
        dec_s    = decode(instr, rs_val, rt_val);
        accept_s = in_valid & ~skid_valid_r;
        load_s   = ~out_valid_r | out_ready;
    end

    // Output register plus skid entry; skid always drains into the output before new input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r        <= '0;
            skid_r       <= '0;
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
        end else if (flush) begin
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
        end else if (load_s) begin
            if (skid_valid_r) begin
                out_r        <= skid_r;
                out_valid_r  <= 1'b1;
                skid_valid_r <= 1'b0;
            end else if (accept_s) begin
                out_r       <= dec_s;
                out_valid_r <= 1'b1;
            end else begin
                out_valid_r <= 1'b0;
            end
        end else if (accept_s) begin
            skid_r       <= dec_s;
            skid_valid_r <= 1'b1;
        end else begin
            skid_valid_r <= skid_valid_r;
        end
    end

    assign in_ready  = ~skid_valid_r;
    assign out_valid = out_valid_r;
    assign alu_con   = out_r.alu_con;
    assign op_a      = out_r.op_a;
    assign op_b      = out_r.op_b;
    assign dest      = out_r.dest;
    assign chk_ov    = out_r.chk_ov;
    assign is_branch = out_r.is_branch;
    assign illegal   = out_r.illegal;

endmodule
